// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions,
// fetch FSM state encoding and the legal-opcode predicate.
package cpu_pkg;

  localparam logic [5:0] OP_ADD      = 6'd0;
  localparam logic [5:0] OP_SUB      = 6'd1;
  localparam logic [5:0] OP_MUL      = 6'd2;
  localparam logic [5:0] OP_AND      = 6'd3;
  localparam logic [5:0] OP_OR       = 6'd4;
  localparam logic [5:0] OP_ADDI     = 6'd5;
  localparam logic [5:0] OP_LBD      = 6'd10;
  localparam logic [5:0] OP_LDW      = 6'd11;
  localparam logic [5:0] OP_STB      = 6'd12;
  localparam logic [5:0] OP_STW      = 6'd13;
  localparam logic [5:0] OP_MOV      = 6'd14;
  localparam logic [5:0] OP_BEQ      = 6'd20;
  localparam logic [5:0] OP_JUMP     = 6'd21;
  localparam logic [5:0] OP_TLBWRITE = 6'd30;
  localparam logic [5:0] OP_IRET     = 6'd31;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_ADDI,
      OP_LBD, OP_LDW, OP_STB, OP_STW, OP_MOV,
      OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus. The fetch stage is the master,
// the memory is the slave.
interface instr_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instr_split.sv
// Combinational instruction field slicer plus illegal-opcode flag,
// reusable by later decode stages.
module instr_split
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic [5:0]  op_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [15:0] imm_o,
  output logic        illegal_op_o
);

  assign op_o         = instr_i[OP_MSB:OP_LSB];
  assign rs_o         = instr_i[RS_MSB:RS_LSB];
  assign rt_o         = instr_i[RT_MSB:RT_LSB];
  assign rd_o         = instr_i[RD_MSB:RD_LSB];
  assign imm_o        = instr_i[IMM_MSB:IMM_LSB];
  assign illegal_op_o = valid_i & ~is_legal_op(instr_i[OP_MSB:OP_LSB]);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, issues one outstanding imem read at a time and
// presents the registered instruction. Optional counters under FETCH_PERF_CNT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [15:0]        imm,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               illegal_op
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               discard_q, discard_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  redir_tgt_s;
  logic               fetch_ok_s;

  assign redir_tgt_s = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign fetch_ok_s  = (state_q == S_WAIT) & imem.rvalid & ~discard_q & ~redirect;

  // Request is gated while in reset so the bus is quiet until the FSM runs.
  assign imem.req  = (state_q == S_REQ) & ~rst;
  assign imem.addr = pc_q;

  // Next-state and datapath update logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d    = redir_tgt_s;
          valid_d = 1'b0;
          if (imem.gnt) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end else begin
            state_d   = S_REQ;
          end
        end else if (imem.gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(3'd4);
          state_d  = S_WAIT;
        end else begin
          state_d  = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = redir_tgt_s;
          valid_d = 1'b0;
          // A response arriving with the redirect is simply dropped here.
          if (imem.rvalid) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end else if (imem.rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            instr_d  = imem.rdata;
            pc_out_d = req_pc_q;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt_s;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        valid_d   = 1'b0;
        discard_d = 1'b0;
        state_d   = S_REQ;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= {ADDR_W{1'b0}};
      discard_q <= 1'b0;
      instr_q   <= {INSTR_W{1'b0}};
      pc_out_q  <= {ADDR_W{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;

  instr_split u_split (
    .instr_i      (instr_q[31:0]),
    .valid_i      (valid_q),
    .op_o         (op),
    .rs_o         (rs),
    .rt_o         (rt),
    .rd_o         (rd),
    .imm_o        (imm),
    .illegal_op_o (illegal_op)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Performance counters: accepted fetches and stalled hold cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (fetch_ok_s) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state_q == S_HOLD) && stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_fetch_ok_s;
  assign unused_fetch_ok_s = fetch_ok_s;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; honours FETCH_PERF_CNT_EN.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] pc_out;
  logic        illegal_op;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .pc_out      (pc_out),
    .illegal_op  (illegal_op)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    bus.gnt     = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'h0;
    #2;
    chk("rst_req",   32'(bus.req),     32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr,            32'h0);
    chk("rst_pcout", pc_out,           32'h0);
    chk("rst_ill",   32'(illegal_op),  32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("t1_req",  32'(bus.req), 32'h1);
    chk("t1_addr", bus.addr,     32'h0);

    // Test 1: basic fetch of 0x00221820 at address 0
    bus.gnt = 1'b1; step();
    bus.gnt = 1'b0;
    chk("t1_req_wait", 32'(bus.req), 32'h0);
    bus.rvalid = 1'b1; bus.rdata = 32'h00221820; step();
    bus.rvalid = 1'b0;
    chk("t1_valid", 32'(instr_valid), 32'h1);
    chk("t1_op",    32'(op),          32'h0);
    chk("t1_rs",    32'(rs),          32'h1);
    chk("t1_rt",    32'(rt),          32'h2);
    chk("t1_rd",    32'(rd),          32'h3);
    chk("t1_pcout", pc_out,           32'h0);
    step();
    chk("t1_next_req",   32'(bus.req),     32'h1);
    chk("t1_next_addr",  bus.addr,         32'h4);
    chk("t1_next_valid", 32'(instr_valid), 32'h0);

    // Test 2: 5-cycle stall holding 0x28220010
    bus.gnt = 1'b1; step();
    bus.gnt = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h28220010; stall = 1'b1; step();
    bus.rvalid = 1'b0; bus.rdata = 32'h0;
    chk("t2_op",    32'(op),  32'd10);
    chk("t2_imm",   32'(imm), 32'h0010);
    chk("t2_pcout", pc_out,   32'h4);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(instr_valid), 32'h1);
      chk("t2_hold_instr", instr,            32'h28220010);
      chk("t2_hold_req",   32'(bus.req),     32'h0);
      step();
    end
    stall = 1'b0; step();
    chk("t2_req",   32'(bus.req),     32'h1);
    chk("t2_addr",  bus.addr,         32'h8);
    chk("t2_valid", 32'(instr_valid), 32'h0);

    // Test 3: redirect while waiting, stale response arrives later
    bus.gnt = 1'b1; step();
    bus.gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100; step();
    redirect = 1'b0;
    chk("t3_wait_req", 32'(bus.req), 32'h0);
    step();
    bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF; step();
    bus.rvalid = 1'b0;
    chk("t3_valid", 32'(instr_valid), 32'h0);
    chk("t3_instr", instr,            32'h28220010);
    chk("t3_req",   32'(bus.req),     32'h1);
    chk("t3_addr",  bus.addr,         32'h100);

    // Test 4: redirect coincident with rvalid, low target bits ignored
    bus.gnt = 1'b1; step();
    bus.gnt = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h11111111;
    redirect = 1'b1; redirect_pc = 32'h203; step();
    bus.rvalid = 1'b0; redirect = 1'b0;
    chk("t4_valid", 32'(instr_valid), 32'h0);
    chk("t4_req",   32'(bus.req),     32'h1);
    chk("t4_addr",  bus.addr,         32'h200);
    bus.gnt = 1'b1; step();
    bus.gnt = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h1C000000; step();
    bus.rvalid = 1'b0;
    chk("t4_op7_valid", 32'(instr_valid), 32'h1);
    chk("t4_op7_ill",   32'(illegal_op),  32'h1);
    chk("t4_op7_pc",    pc_out,           32'h200);
    step();
    chk("t4_ill_clr", 32'(illegal_op), 32'h0);
    chk("t4_addr2",   bus.addr,        32'h204);

    // Test 5: op=31 is legal; stray rvalid in S_REQ is ignored
    bus.rvalid = 1'b1; bus.rdata = 32'hFFFFFFFF; step();
    bus.rvalid = 1'b0;
    chk("t5_stray_valid", 32'(instr_valid), 32'h0);
    chk("t5_stray_req",   32'(bus.req),     32'h1);
    bus.gnt = 1'b1; step();
    bus.gnt = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h7C000000; step();
    bus.rvalid = 1'b0;
    chk("t5_op",    32'(op),         32'd31);
    chk("t5_ill",   32'(illegal_op), 32'h0);
    chk("t5_pcout", pc_out,          32'h204);
    step();
    chk("t5_addr", bus.addr, 32'h208);

    // Test 6: PC wrap from 0xFFFFFFFC
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC; step();
    redirect = 1'b0;
    chk("t6_addr", bus.addr, 32'hFFFFFFFC);
    bus.gnt = 1'b1; step();
    bus.gnt = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h50000000; step();
    bus.rvalid = 1'b0;
    chk("t6_pcout", pc_out,          32'hFFFFFFFC);
    chk("t6_op",    32'(op),         32'd20);
    chk("t6_ill",   32'(illegal_op), 32'h0);
    step();
    chk("t6_wrap_addr", bus.addr, 32'h0);

    // Test 7: redirect with grant in S_REQ, then redirect while stalled in S_HOLD
    redirect = 1'b1; redirect_pc = 32'h40; bus.gnt = 1'b1; step();
    redirect = 1'b0; bus.gnt = 1'b0;
    chk("t7_wait_req", 32'(bus.req), 32'h0);
    bus.rvalid = 1'b1; bus.rdata = 32'h22222222; step();
    bus.rvalid = 1'b0;
    chk("t7_drop_valid", 32'(instr_valid), 32'h0);
    chk("t7_addr",       bus.addr,         32'h40);
    bus.gnt = 1'b1; step();
    bus.gnt = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h04000000; stall = 1'b1; step();
    bus.rvalid = 1'b0;
    chk("t7_hold_pc", pc_out,   32'h40);
    chk("t7_hold_op", 32'(op),  32'd1);
    redirect = 1'b1; redirect_pc = 32'h80; step();
    redirect = 1'b0; stall = 1'b0;
    chk("t7_redir_valid", 32'(instr_valid), 32'h0);
    chk("t7_redir_addr",  bus.addr,         32'h80);
    chk("t7_redir_req",   32'(bus.req),     32'h1);

`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", fetch_cnt, 32'd6);
    chk("perf_stall", stall_cnt, 32'd6);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
